// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative 32-bit logical left shifter.
// Holds the FSM state enum, the datapath widths and the stage count.
package shift_pkg;

  localparam int XLEN     = 32;
  localparam int SHAMT_W  = 5;
  localparam int N_STAGES = 5;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sll_stage.sv
// One conditional shift stage: o_data = i_en ? i_data << 2^i_k : i_data.
// Ports: i_data operand, i_en stage enable, i_k stage index, o_data result.
module sll_stage #(
  parameter int XLEN = 32,
  parameter int KW   = 3
) (
  input  logic [XLEN-1:0] i_data,
  input  logic            i_en,
  input  logic [KW-1:0]   i_k,
  output logic [XLEN-1:0] o_data
);

  logic [5:0] w_amt;

  assign w_amt  = 6'd1 << i_k;
  assign o_data = i_en ? (i_data << w_amt) : i_data;

endmodule

// File: rtl/sll_iter_32bit.sv
// Iterative logical left shifter: one binary stage (16,8,4,2,1) per cycle.
// Ports: clk_i, rst_i (sync, high); valid_i/ready_o + a_i/shift_i request;
// valid_o/ready_i + s_o result; busy_o while SHIFT or DONE.
module sll_iter_32bit #(
  parameter int XLEN    = shift_pkg::XLEN,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [XLEN-1:0]    a_i,
  input  logic [SHAMT_W-1:0] shift_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    s_o,
  output logic               busy_o
);

  import shift_pkg::*;

  state_t             r_state;
  state_t             w_nxt;
  logic [XLEN-1:0]    r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic [CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]    r_s;
  logic [XLEN-1:0]    w_stage;
  logic               w_en;
  logic               w_acc;

  assign w_en  = r_shamt[r_cnt];
  assign w_acc = (r_state == S_IDLE) && valid_i;

  sll_stage #(
    .XLEN (XLEN),
    .KW   (CNT_W)
  ) u_stage (
    .i_data (r_data),
    .i_en   (w_en),
    .i_k    (r_cnt),
    .o_data (w_stage)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (valid_i)     w_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_nxt = S_DONE;
      S_DONE:  if (ready_i)     w_nxt = S_IDLE;
      default:                  w_nxt = S_IDLE;
    endcase
  end

  // Counter saturates at 0: the last stage hands the result to r_s
  // instead of decrementing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_shamt <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
    end else if (w_acc) begin
      r_data  <= a_i;
      r_shamt <= shift_i;
      r_cnt   <= CNT_W'(N_STAGES - 1);
    end else if (r_state == S_SHIFT) begin
      r_data <= w_stage;
      if (r_cnt == '0) r_s   <= w_stage;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);
  assign busy_o  = (r_state != S_IDLE);
  assign s_o     = r_s;

endmodule

// File: tb/tb_sll_iter_32bit.sv
// Self-checking bench for sll_iter_32bit: directed and random requests
// checked against a << sh, fixed latency, hold, and reset behaviour.
module tb_sll_iter_32bit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [4:0]  shift_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] s_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  sll_iter_32bit dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .shift_i (shift_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .s_o     (s_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] ref_sll(input logic [31:0] a,
                                          input int sh);
    logic [63:0] w;
    w = {32'd0, a} * (64'd1 << sh);
    return w[31:0];
  endfunction

  // One full transaction; inputs are scrambled while the block is busy.
  task automatic run(input logic [31:0] a, input logic [4:0] sh,
                     input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_sll(a, int'(sh));
    chk("ready_before", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1;
    a_i     = a;
    shift_i = sh;
    tick();
    chk("busy_after_acc", {31'd0, busy_o}, 32'd1);
    lat = 1;
    while (!valid_o && lat < 20) begin
      valid_i = 1'($urandom);
      a_i     = $urandom;
      shift_i = 5'($urandom);
      tick();
      chk("no_reaccept", {31'd0, ready_o}, 32'd0);
      lat++;
    end
    valid_i = 1'b0;
    chk("latency", 32'(lat), 32'd6);
    chk("result", s_o, exp);
    for (int i = 0; i < hold; i++) begin
      a_i = $urandom;
      tick();
      chk("hold_valid", {31'd0, valid_o}, 32'd1);
      chk("hold_s", s_o, exp);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("idle_ready", {31'd0, ready_o}, 32'd1);
    chk("idle_valid", {31'd0, valid_o}, 32'd0);
    chk("retain_s", s_o, exp);
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b0;
    a_i     = 32'hCAFEF00D;
    shift_i = 5'd3;
    tick();
    tick();
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_s", s_o, 32'd0);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    tick();
    chk("no_acc_in_rst", {31'd0, busy_o}, 32'd0);

    run(32'h00000001, 5'd31, 0);
    run(32'hFFFFFFFF, 5'd4, 1);
    run(32'h12345678, 5'd8, 0);
    run(32'hDEADBEEF, 5'd0, 3);

    // Reset in the middle of a shift discards the in-flight result.
    valid_i = 1'b1;
    a_i     = 32'h0000F00F;
    shift_i = 5'd12;
    tick();
    valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_s", s_o, 32'd0);
    run(32'h0000F00F, 5'd12, 1);

    for (int t = 0; t < 40; t++)
      run($urandom, 5'($urandom), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
